rr_arbiter: RTL
===============

Name: rr_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the operand/bus `mux`.
- Takes N request lines and picks one fairly.
- Drives the mux select (`o_select`, wired straight to the mux `i_select`) and a one-hot grant.
- Runs a valid/ready handshake toward the downstream consumer of the mux output, and returns a per-requester acknowledge when a beat is consumed.

Parameters:
- NUM_INPUTS, 4, number of requesters; must be >= 2; need not be a power of two.
- SEL_W, $clog2(NUM_INPUTS), select width; derived, not overridden.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_request  input  NUM_INPUTS  per-requester request; must hold until acked.
- i_ready  input  1  downstream accepts the current mux output this cycle.
- i_last  input  1  last beat of a burst; port present only with ARB_LOCK_EN.
- o_select  output  SEL_W  index of the granted input; drives mux i_select.
- o_grant  output  NUM_INPUTS  one-hot registered grant.
- o_valid  output  1  mux output is valid.
- o_ack  output  NUM_INPUTS  one-hot; beat of that requester consumed this cycle.

Behaviour:
- Reset (asynchronous, immediate, also mid-transfer): state=IDLE, o_grant=0, o_select=0, pointer=0; o_valid=0, o_ack=0.
- Pointer: index with highest priority. The winner is the first set bit of i_request scanning pointer, pointer+1, ..., wrapping from NUM_INPUTS-1 to 0.
- IDLE:
  - If |i_request, register winner into o_grant/o_select and go to BUSY.
  - Latency is 1 cycle from request to grant.
  - Otherwise stay in IDLE with grant 0.
- BUSY:
  - o_valid = |(i_request & o_grant), combinational.
  - Handshake = o_valid & i_ready.
  - o_ack = o_grant when handshake is true, else 0.
- On handshake:
  - pointer <= granted index + 1, with wrap.
  - Re-arbitrate in the same cycle over current i_request using the new pointer.
  - If a winner exists, load it and stay in BUSY (no bubble).
  - Otherwise clear grant and go to IDLE.
- No handshake (i_ready=0): o_grant/o_select held stable, pointer unchanged.
- Granted requester drops its request before the handshake (protocol violation): o_valid goes 0 immediately. Next edge clears grant and returns to IDLE; pointer unchanged; no ack.
- Requests arriving while BUSY do not preempt the current grant.
- Non-granted requests never produce o_ack.
- Single continuous requester: re-granted every beat, back-to-back.
- o_select is always in range 0..NUM_INPUTS-1.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - i_last port exists.
  - A handshake with i_last=0 keeps the grant and does not advance the pointer (burst lock).
  - Only a handshake with i_last=1 advances the pointer and re-arbitrates as above.
- Undefined:
  - No i_last port.
  - Every handshake re-arbitrates, i.e. every beat is treated as last.

Decomposition:
- Shared package arb_pkg holds:
  - typedef of the 1-bit state enum {ARB_IDLE, ARB_BUSY};
  - a function sel_width(n) returning $clog2(n) with a minimum of 1.
- One sub-module is natural: rr_pick.
  - Combinational: inputs request vector and pointer.
  - Outputs: found, index, one-hot.
  - Implemented as a double-width masked priority encode.
  - Instantiated once, in the re-arbitration path.

Test Plan (NUM_INPUTS=4):
- Reset: i_rst_n=0 asserted mid-BUSY with grant 0010 -> o_grant=0000, o_select=0, o_valid=0 immediately; after release with i_request=0, remains idle.
- Single requester: i_request=0100, i_ready=1 -> next cycle o_grant=0100, o_select=2, o_valid=1, o_ack=0100; pointer then 3.
- Fairness: i_request=1111 held, i_ready=1 -> o_select sequence 0,1,2,3,0,1 on consecutive cycles, no idle cycle.
- Backpressure: i_request=0011, i_ready=0 for 3 cycles -> o_select=0 and o_grant=0001 stable, o_ack=0; then i_ready=1 -> o_ack=0001, next cycle o_select=1.
- Withdrawal: grant 0001 in BUSY, i_request[0] drops -> o_valid=0 same cycle, IDLE next cycle, no ack; then i_request=0001 re-grants index 0.
- Lock (ARB_LOCK_EN): i_request=0011, i_ready=1, i_last=0,0,1 -> o_select=0 for three beats, then 1.
- Lock check without the macro: the same stimulus alternates 0,1,0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter slice.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after the pointer, with wrap.
module rr_pick
    import arb_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    localparam int SEL_W = sel_width(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] i_request,
    input  logic [SEL_W-1:0]      i_pointer,
    output logic                  o_found,
    output logic [SEL_W-1:0]      o_index,
    output logic [NUM_INPUTS-1:0] o_onehot
);

    logic [2*NUM_INPUTS-1:0] doubled;
    logic [2*NUM_INPUTS-1:0] masked;

    // Doubling the vector turns the wrap-around scan into a plain lowest-bit search above the pointer.
    always_comb begin
        doubled  = {i_request, i_request};
        masked   = '0;
        o_found  = 1'b0;
        o_index  = '0;
        o_onehot = '0;
        for (int unsigned i = 0; i < 2 * NUM_INPUTS; i++) begin
            masked[i] = doubled[i] && (i >= 32'(i_pointer));
        end
        for (int unsigned i = 0; i < 2 * NUM_INPUTS; i++) begin
            if (masked[i] && !o_found) begin
                o_found = 1'b1;
                o_index = (i >= 32'(NUM_INPUTS)) ? SEL_W'(i - 32'(NUM_INPUTS)) : SEL_W'(i);
            end
        end
        if (o_found) begin
            o_onehot[o_index] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter driving a mux select with a valid/ready handshake and per-requester ack.
// Optional burst lock enabled by defining ARB_LOCK_EN (adds the i_last port).
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    localparam int SEL_W = sel_width(NUM_INPUTS)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NUM_INPUTS-1:0] i_request,
    input  logic                  i_ready,
`ifdef ARB_LOCK_EN
    input  logic                  i_last,
`endif
    output logic [SEL_W-1:0]      o_select,
    output logic [NUM_INPUTS-1:0] o_grant,
    output logic                  o_valid,
    output logic [NUM_INPUTS-1:0] o_ack
);

    arb_state_e            state;
    logic [SEL_W-1:0]      pointer;
    logic [SEL_W-1:0]      next_ptr;
    logic [SEL_W-1:0]      pick_ptr;
    logic                  pick_found;
    logic [SEL_W-1:0]      pick_index;
    logic [NUM_INPUTS-1:0] pick_onehot;
    logic                  handshake;
    logic                  beat_last;
    logic                  advance;

    assign o_valid   = (state == ARB_BUSY) && (|(i_request & o_grant));
    assign handshake = o_valid & i_ready;
    assign o_ack     = handshake ? o_grant : '0;

`ifdef ARB_LOCK_EN
    assign beat_last = i_last;
`else
    assign beat_last = 1'b1;
`endif

    assign advance  = handshake & beat_last;
    assign next_ptr = (o_select == SEL_W'(NUM_INPUTS - 1)) ? '0 : o_select + SEL_W'(1);
    // While busy the only pick that matters is the one taken on an advancing beat.
    assign pick_ptr = (state == ARB_BUSY) ? next_ptr : pointer;

    rr_pick #(
        .NUM_INPUTS(NUM_INPUTS)
    ) u_pick (
        .i_request(i_request),
        .i_pointer(pick_ptr),
        .o_found  (pick_found),
        .o_index  (pick_index),
        .o_onehot (pick_onehot)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ARB_IDLE;
            o_grant  <= '0;
            o_select <= '0;
            pointer  <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_found) begin
                        o_grant  <= pick_onehot;
                        o_select <= pick_index;
                        state    <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (!o_valid) begin
                        o_grant  <= '0;
                        o_select <= '0;
                        state    <= ARB_IDLE;
                    end else if (advance) begin
                        pointer <= next_ptr;
                        if (pick_found) begin
                            o_grant  <= pick_onehot;
                            o_select <= pick_index;
                        end else begin
                            o_grant  <= '0;
                            o_select <= '0;
                            state    <= ARB_IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule
